// File: rtl/adc_xbar_shadow.sv
// Shadowed ADC sample crossbar: per-output {sel, mode} routing with a commit
// that swaps shadow into active only on a sample boundary.
module adc_xbar_shadow #(
  parameter int WIDTH     = 8,
  parameter int IN_PORTS  = 4,
  parameter int OUT_PORTS = 4,
  parameter int OUT_FF    = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cfg_wr,
  input  logic [7:0]                     cfg_addr,
  input  logic [7:0]                     cfg_sel,
  input  logic [1:0]                     cfg_mode,
  input  logic                           commit,
  output logic                           cfg_err,
  output logic                           commit_pend,
  output logic                           commit_done,
  output logic [7:0]                     commit_cnt,
  input  logic                           in_valid,
  input  logic [IN_PORTS*WIDTH-1:0]      in_data,
  output logic                           out_valid,
  output logic [OUT_PORTS*WIDTH-1:0]     out_data
);

  localparam int SW = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                     state;
  logic [SW-1:0]              sh_sel   [OUT_PORTS];
  logic [1:0]                 sh_mode  [OUT_PORTS];
  logic [SW-1:0]              act_sel  [OUT_PORTS];
  logic [1:0]                 act_mode [OUT_PORTS];
  logic [SW-1:0]              nx_sel   [OUT_PORTS];
  logic [1:0]                 nx_mode  [OUT_PORTS];
  logic [SW-1:0]              eff_sel  [OUT_PORTS];
  logic [1:0]                 eff_mode [OUT_PORTS];
  logic                       wr_ok;
  logic                       apply;
  logic                       v1;
  logic [OUT_PORTS*WIDTH-1:0] s1;
  logic [OUT_PORTS*WIDTH-1:0] s1_nxt;
  logic [WIDTH-1:0]           src;

  assign wr_ok = cfg_wr && (32'(cfg_addr) < OUT_PORTS) && (32'(cfg_sel) < IN_PORTS);
  assign apply = (state == PEND) && in_valid;
  assign commit_pend = (state == PEND);

  // The applying sample already uses the new table, including a same-cycle write,
  // so every sample sees either the full old table or the full new one.
  always_comb begin
    for (int o = 0; o < OUT_PORTS; o++) begin
      nx_sel[o]  = sh_sel[o];
      nx_mode[o] = sh_mode[o];
      if (wr_ok && (32'(cfg_addr) == o)) begin
        nx_sel[o]  = cfg_sel[SW-1:0];
        nx_mode[o] = cfg_mode;
      end
      eff_sel[o]  = apply ? nx_sel[o]  : act_sel[o];
      eff_mode[o] = apply ? nx_mode[o] : act_mode[o];
    end
  end

  always_comb begin
    s1_nxt = s1;
    src    = '0;
    for (int o = 0; o < OUT_PORTS; o++) begin
      src = in_data[32'(eff_sel[o])*WIDTH +: WIDTH];
      case (eff_mode[o])
        2'd0:    s1_nxt[o*WIDTH +: WIDTH] = src;
        2'd1:    s1_nxt[o*WIDTH +: WIDTH] = (src == MIN_VAL) ? MAX_VAL : (~src + 1'b1);
        2'd2:    s1_nxt[o*WIDTH +: WIDTH] = '0;
        default: s1_nxt[o*WIDTH +: WIDTH] = s1[o*WIDTH +: WIDTH];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cfg_err     <= 1'b0;
      commit_done <= 1'b0;
      commit_cnt  <= 8'd0;
      v1          <= 1'b0;
      s1          <= '0;
      for (int i = 0; i < OUT_PORTS; i++) begin
        sh_sel[i]   <= SW'(i % IN_PORTS);
        sh_mode[i]  <= 2'd0;
        act_sel[i]  <= SW'(i % IN_PORTS);
        act_mode[i] <= 2'd0;
      end
    end else begin
      commit_done <= apply;
      cfg_err     <= cfg_err | (cfg_wr & ~wr_ok);
      for (int i = 0; i < OUT_PORTS; i++) begin
        sh_sel[i]  <= nx_sel[i];
        sh_mode[i] <= nx_mode[i];
      end
      case (state)
        IDLE: if (commit) state <= PEND;
        PEND: if (in_valid) begin
          for (int i = 0; i < OUT_PORTS; i++) begin
            act_sel[i]  <= nx_sel[i];
            act_mode[i] <= nx_mode[i];
          end
          commit_cnt <= commit_cnt + 8'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      v1 <= in_valid;
      if (in_valid) s1 <= s1_nxt;
    end
  end

  if (OUT_FF != 0) begin : g_two_stage
    logic                       v2;
    logic [OUT_PORTS*WIDTH-1:0] s2;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v2 <= 1'b0;
        s2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) s2 <= s1;
      end
    end
    assign out_valid = v2;
    assign out_data  = s2;
  end else begin : g_one_stage
    assign out_valid = v1;
    assign out_data  = s1;
  end

endmodule

// File: tb/tb_adc_xbar_shadow.sv
// Directed bench for adc_xbar_shadow (4x4, WIDTH=8, OUT_FF=1).
module tb_adc_xbar_shadow;
  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_sel;
  logic [1:0]  cfg_mode;
  logic        commit;
  logic        cfg_err;
  logic        commit_pend;
  logic        commit_done;
  logic [7:0]  commit_cnt;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;

  adc_xbar_shadow #(.WIDTH(8), .IN_PORTS(4), .OUT_PORTS(4), .OUT_FF(1)) dut (
    .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .commit(commit), .cfg_err(cfg_err),
    .commit_pend(commit_pend), .commit_done(commit_done), .commit_cnt(commit_cnt),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] a, input logic [7:0] s, input logic [1:0] m);
    cfg_wr = 1'b1; cfg_addr = a; cfg_sel = s; cfg_mode = m;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic sample(input logic [31:0] d);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_mode = '0;
    commit = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {29'd0, cfg_err, commit_pend, commit_done}, 32'd0);
    chk("rst_cnt", 32'(commit_cnt), 32'd0);
    resetn = 1'b1;
    tick();

    // identity, two-cycle latency
    in_data = 32'h44332211; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("id_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("id_valid", 32'(out_valid), 32'd1);
    chk("id_data", out_data, 32'h44332211);

    // back-to-back samples
    in_data = 32'h01020304; in_valid = 1'b1;
    tick();
    in_data = 32'h0A0B0C0D;
    tick();
    chk("b2b_a", out_data, 32'h01020304);
    in_data = 32'hF0E0D0C0;
    tick();
    chk("b2b_b", out_data, 32'h0A0B0C0D);
    chk("b2b_b_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_c", out_data, 32'hF0E0D0C0);
    tick();
    chk("b2b_idle_valid", 32'(out_valid), 32'd0);
    chk("b2b_hold_data", out_data, 32'hF0E0D0C0);

    // atomic commit across 5 idle cycles
    sample(32'h44332211);
    chk("pre_commit_data", out_data, 32'h44332211);
    cfg(8'd0, 8'd3, 2'd0);
    cfg(8'd1, 8'd2, 2'd0);
    do_commit();
    for (int i = 0; i < 5; i++) begin
      chk("pend_wait", 32'(commit_pend), 32'd1);
      tick();
    end
    in_data = 32'h44332211; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("apply_pend", 32'(commit_pend), 32'd0);
    chk("apply_done", 32'(commit_done), 32'd1);
    chk("apply_cnt", 32'(commit_cnt), 32'd1);
    tick();
    chk("apply_done_pulse", 32'(commit_done), 32'd0);
    chk("apply_data", out_data, 32'h44333344);

    // modes
    cfg(8'd2, 8'd2, 2'd1);
    do_commit();
    sample(32'h44802211);
    chk("neg_sat", out_data, 32'h447F8044);
    sample(32'h44052211);
    chk("neg_5", out_data, 32'h44FB0544);
    cfg(8'd2, 8'd2, 2'd2);
    do_commit();
    sample(32'h44052211);
    chk("zero", out_data, 32'h44000544);
    cfg(8'd3, 8'd0, 2'd3);
    do_commit();
    sample(32'h99052211);
    chk("hold_1", out_data, 32'h44000599);
    sample(32'hAA0522CC);
    chk("hold_2", out_data, 32'h440005AA);
    chk("mode_cnt", 32'(commit_cnt), 32'd4);

    // rejected writes
    cfg(8'd0, 8'd4, 2'd0);
    chk("err_sel", 32'(cfg_err), 32'd1);
    cfg(8'd4, 8'd0, 2'd0);
    chk("err_addr", 32'(cfg_err), 32'd1);
    do_commit();
    sample(32'h11223344);
    chk("err_routing", out_data, 32'h44002211);
    chk("err_cnt", 32'(commit_cnt), 32'd5);

    // commit coincident with in_valid in IDLE waits for the next sample
    cfg(8'd2, 8'd1, 2'd0);
    commit = 1'b1; in_data = 32'h11223344; in_valid = 1'b1;
    tick();
    commit = 1'b0; in_valid = 1'b0;
    chk("coinc_pend", 32'(commit_pend), 32'd1);
    tick();
    chk("coinc_old", out_data, 32'h44002211);
    sample(32'h11223344);
    chk("coinc_new", out_data, 32'h44332211);
    chk("coinc_cnt", 32'(commit_cnt), 32'd6);

    // commits absorbed in PEND; write in the applying cycle is included
    commit = 1'b1;
    tick(); tick(); tick();
    commit = 1'b0;
    chk("absorb_pend", 32'(commit_pend), 32'd1);
    chk("absorb_cnt_hold", 32'(commit_cnt), 32'd6);
    cfg_wr = 1'b1; cfg_addr = 8'd1; cfg_sel = 8'd0; cfg_mode = 2'd0;
    in_data = 32'h11223344; in_valid = 1'b1;
    tick();
    cfg_wr = 1'b0; in_valid = 1'b0;
    chk("absorb_done", 32'(commit_done), 32'd1);
    tick();
    chk("absorb_done_once", 32'(commit_done), 32'd0);
    chk("late_wr_data", out_data, 32'h44334411);
    chk("absorb_cnt", 32'(commit_cnt), 32'd7);

    // counter wrap
    for (int i = 0; i < 248; i++) begin
      do_commit();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    chk("cnt_255", 32'(commit_cnt), 32'd255);
    do_commit();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("cnt_wrap", 32'(commit_cnt), 32'd0);

    // reset while pending
    cfg(8'd0, 8'd1, 2'd0);
    do_commit();
    chk("rp_pend", 32'(commit_pend), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rp_pend_clr", 32'(commit_pend), 32'd0);
    chk("rp_cnt", 32'(commit_cnt), 32'd0);
    chk("rp_err", 32'(cfg_err), 32'd0);
    chk("rp_out", out_data, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    sample(32'h44332211);
    chk("rp_identity", out_data, 32'h44332211);
    chk("rp_valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_xbar_shadow.md
ADC_XBAR_SHADOW -- requirements
Module: adc_xbar_shadow

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits per port.
REQ-002 Parameter IN_PORTS, default 4: number of input sample ports, 1..256.
REQ-003 Parameter OUT_PORTS, default 4: number of output sample ports, 1..256.
REQ-004 Parameter OUT_FF, default 1: 0 = one registered stage; 1 = two registered stages.
REQ-005 clk  in  1  single clock for all logic; one clock, reset asynchronous active-low.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 cfg_wr  in  1  one-cycle write strobe for a shadow table entry.
REQ-008 cfg_addr  in  8  output port index to write.
REQ-009 cfg_sel  in  8  input port index to route to that output.
REQ-010 cfg_mode  in  2  per-output mode: 0 pass, 1 negate, 2 force zero, 3 hold last.
REQ-011 commit  in  1  one-cycle request to copy the shadow table to the active table.
REQ-012 cfg_err  out  1  sticky flag, set on a rejected write.
REQ-013 commit_pend  out  1  high while a commit is waiting for a sample boundary.
REQ-014 commit_done  out  1  one-cycle pulse when the active table is updated.
REQ-015 commit_cnt  out  8  count of applied commits, wraps 255->0.
REQ-016 in_valid  in  1  input sample strobe.
REQ-017 in_data  in  IN_PORTS*WIDTH  flat input samples; port k occupies bits [k*WIDTH +: WIDTH].
REQ-018 out_valid  out  1  output sample strobe.
REQ-019 out_data  out  OUT_PORTS*WIDTH  flat output samples, same packing as in_data.

Function
REQ-020 Two tables, each OUT_PORTS entries of {sel, mode}:
- shadow: written by cfg_wr.
- active: drives the datapath.
REQ-021 cfg_wr with cfg_addr < OUT_PORTS and cfg_sel < IN_PORTS SHALL update the shadow entry on the next edge.
REQ-022 cfg_wr with cfg_addr >= OUT_PORTS or cfg_sel >= IN_PORTS SHALL leave the shadow table unchanged and set cfg_err.
- cfg_err clears only on reset.
REQ-023 Commit state machine, states IDLE and PEND:
- IDLE + commit -> PEND.
- In PEND, a cycle with in_valid=1 copies all shadow entries to active atomically, pulses commit_done in the following cycle, increments commit_cnt, and returns to IDLE.
REQ-024 commit in the same cycle as in_valid, while in IDLE, SHALL be applied on the next in_valid, never the current one.
- No output sample may ever be built from a mix of old and new entries.
REQ-025 commit while in PEND SHALL be absorbed (no second commit, no counter change).
REQ-026 cfg_wr while in PEND SHALL reach the shadow table and be included in the pending commit if it lands no later than the cycle of the applying in_valid.
REQ-027 Stage 1, registered on in_valid:
- route in_data[sel] per output.
- mode 0: pass.
- mode 1: two's-complement negate, saturating -2^(WIDTH-1) to 2^(WIDTH-1)-1.
- mode 2: zero.
- mode 3: keep the previous stage-1 value of that output.
REQ-028 OUT_FF=1 adds a second register stage.
REQ-029 out_valid SHALL equal in_valid delayed by exactly 1+OUT_FF cycles; out_data SHALL change only in cycles where out_valid is asserted.
REQ-030 Back-to-back in_valid (every cycle) SHALL be sustained with no bubbles.

Reset
REQ-031 While resetn=0, all outputs SHALL be 0:
- out_data, out_valid, cfg_err, commit_pend, commit_done, commit_cnt.
- State SHALL be IDLE and pipeline valids cleared.
REQ-032 Reset value of shadow and active entry i SHALL be sel = i mod IN_PORTS, mode 0 (identity map).
REQ-033 Reset asserted while in PEND SHALL discard the pending commit; pending shadow writes are lost.

Verification
REQ-034 Identity: after reset, IN_PORTS=OUT_PORTS=4, WIDTH=8, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=1 -> out_data={8'h44,8'h33,8'h22,8'h11}, 2 cycles later (OUT_FF=1).
REQ-035 Atomic commit:
- Stimulus: write out0<-in3 and out1<-in2, commit, with in_valid low for 5 cycles, then in_valid.
- Response: commit_pend high for those 5 cycles; commit_done pulses once; commit_cnt=1; the first sample after the boundary shows both new routes, the sample before shows neither.
REQ-036 Modes:
- out2 in mode 1 fed 8'h80 -> 8'h7F; fed 8'h05 -> 8'hFB.
- mode 2 -> 8'h00.
- mode 3: output holds while the input changes.
REQ-037 Errors: cfg_sel=4 or cfg_addr=4 (4x4 config) -> cfg_err=1; shadow unchanged; the next commit leaves routing identical.
REQ-038 Corners:
- commit while PEND -> single increment.
- commit_cnt 255 -> 0 on the 256th commit.
- resetn pulsed low during PEND -> commit_pend=0, identity routing restored, commit_cnt=0.
